// File: rtl/ftoi_wb.sv
// ftoi_wb: pairs each ftoi result with its destination tag and queues the pair for integer writeback
module ftoi_wb #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  input  logic [31:0]      y,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic             p_valid_q, p_valid_d;
  logic [TAG_W-1:0] p_tag_q, p_tag_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TAG_W+31:0] mem_q [DEPTH];
  logic             push, pop;
  // Issue gating and head presentation; in_ready counts the in-flight result so it always finds a slot
  always_comb begin
    push      = p_valid_q;
    out_valid = count_q != '0;
    pop       = out_valid && out_ready;
    in_ready  = (count_q + CW'(p_valid_q)) < DEPTH_C;
    out_data  = out_valid ? mem_q[rd_q][31:0] : '0;
    out_tag   = out_valid ? mem_q[rd_q][TAG_W+31:32] : '0;
    count     = count_q;
    p_valid_d = in_valid && in_ready;
    p_tag_d   = p_valid_d ? in_tag : p_tag_q;
    wr_d      = push ? wr_q + AW'(1) : wr_q;
    rd_d      = pop ? rd_q + AW'(1) : rd_q;
    count_d   = count_q + CW'(push) - CW'(pop);
  end
  // Tag stage, pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_valid_q <= 1'b0;
      p_tag_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_tag_q   <= p_tag_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
    end
  end
  // Storage: y is the result for p_tag in the cycle p_valid is set
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {p_tag_q, y};
  end
endmodule

// File: tb/tb_ftoi_wb.sv
// tb_ftoi_wb: directed table plus sequences with a scoreboard for the ftoi writeback buffer
module tb_ftoi_wb;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready;
  logic [31:0]      y;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_ready = 1'b0;
  logic [2:0]       count;
  logic [31:0]      xi = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [TAG_W+31:0] sb[$];
  int mc = 0;
  bit pv = 0;
  bit last_acc = 0;

  typedef struct {
    bit iv; logic [TAG_W-1:0] tag; logic [31:0] x; bit ordy;
    bit ir; bit ov; logic [31:0] d; logic [TAG_W-1:0] t; logic [2:0] c;
  } vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;
  // ftoi stand-in: integer result of the x driven this cycle appears registered next cycle
  always @(posedge clk) y <= xi;

  ftoi_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready), .count(count)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit iv, logic [TAG_W-1:0] tg, logic [31:0] xv, bit ordy);
    bit acc, pop;
    @(negedge clk);
    in_valid = iv; in_tag = tg; xi = xv; out_ready = ordy;
    #1;
    chk("count", 32'(count), mc);
    chk("out_valid", 32'(out_valid), 32'(mc != 0));
    chk("in_ready", 32'(in_ready), 32'((mc + int'(pv)) < DEPTH));
    if (!out_valid) begin
      chk("idle_data", out_data, 0);
      chk("idle_tag", 32'(out_tag), 0);
    end
    if (pv) chk("no_overflow_push", 32'(mc < DEPTH), 1);
    acc = iv && in_ready;
    pop = out_valid && ordy;
    if (pop) begin
      chk("sb_nonempty_at_pop", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        chk("pop_tag", 32'(out_tag), 32'(sb[0][TAG_W+31:32]));
        chk("pop_data", out_data, sb[0][31:0]);
        void'(sb.pop_front());
      end
    end
    if (acc) sb.push_back({tg, xv});
    mc = mc + int'(pv) - int'(pop);
    pv = acc;
    last_acc = acc;
  endtask

  task automatic drain();
    int k = 0;
    while ((mc != 0 || pv) && k < 20) begin
      step(0, '0, '0, 1);
      k++;
    end
    chk("drain_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    tbl[0]  = '{1, 5, 32'h0000000A, 0, 1, 0, 32'h0,        0, 0};
    tbl[1]  = '{0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0};
    tbl[2]  = '{0, 0, 32'h0,        1, 1, 1, 32'h0000000A, 5, 1};
    tbl[3]  = '{0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0};
    tbl[4]  = '{1, 1, 32'h00000001, 0, 1, 0, 32'h0,        0, 0};
    tbl[5]  = '{1, 2, 32'hFFFFFFFE, 0, 1, 0, 32'h0,        0, 0};
    tbl[6]  = '{1, 3, 32'h00000000, 0, 1, 1, 32'h00000001, 1, 1};
    tbl[7]  = '{1, 4, 32'hB2D05E00, 0, 1, 1, 32'h00000001, 1, 2};
    tbl[8]  = '{1, 5, 32'h00000007, 0, 0, 1, 32'h00000001, 1, 3};
    tbl[9]  = '{1, 5, 32'h00000007, 0, 0, 1, 32'h00000001, 1, 4};
    tbl[10] = '{1, 5, 32'h00000007, 1, 0, 1, 32'h00000001, 1, 4};
    tbl[11] = '{1, 5, 32'h00000007, 1, 1, 1, 32'hFFFFFFFE, 2, 3};
    tbl[12] = '{0, 0, 32'h0,        1, 1, 1, 32'h00000000, 3, 2};
    tbl[13] = '{0, 0, 32'h0,        1, 1, 1, 32'hB2D05E00, 4, 2};
    tbl[14] = '{0, 0, 32'h0,        1, 1, 1, 32'h00000007, 5, 1};
    tbl[15] = '{0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rstn = 1'b1;

    // single conversion, then fill/stall/drain in order
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].iv, tbl[i].tag, tbl[i].x, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].d);
      chk($sformatf("tbl%0d_out_tag", i), 32'(out_tag), 32'(tbl[i].t));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].c));
    end
    drain();

    // streaming with simultaneous push and pop
    for (int i = 0; i < 20; i++) begin
      step(1, TAG_W'(i), 32'(i * 7 + 1), 1);
      chk("stream_count_le1", 32'(count <= 1), 1);
      chk("stream_in_ready", 32'(in_ready), 1);
    end
    drain();

    // hold under backpressure
    step(1, 40, 32'hDEADBEEF, 0);
    step(1, 41, 32'h12345678, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, '0, '0, 0);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", out_data, 32'hDEADBEEF);
      chk("hold_tag", 32'(out_tag), 40);
    end
    drain();

    // random traffic with pointer wrap
    begin
      int acc_n = 0, cyc = 0;
      while (acc_n < 50 && cyc < 3000) begin
        step(bit'($urandom_range(0, 1)), TAG_W'($urandom), $urandom, bit'($urandom_range(0, 1)));
        if (last_acc) acc_n++;
        cyc++;
      end
      chk("random_issued", 32'(acc_n), 50);
    end
    drain();

    // asynchronous reset with 3 queued and one in flight
    for (int i = 0; i < 4; i++) step(1, TAG_W'(10 + i), 32'(100 + i), 0);
    step(0, '0, '0, 0);
    chk("pre_rst_count", 32'(count), 3);
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", 32'(out_tag), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    sb.delete();
    mc = 0;
    pv = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 4; i++) step(0, '0, 32'h55, 1);
    step(1, 33, 32'hFFFFFF85, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
